// File: rtl/game_status_tx.sv
// Status return path of the host UART link: snapshots game state and bird y,
// then sends a 5-byte 8N1 frame (A5, state, y_hi, y_lo, xor) on tx_pin.
module game_status_tx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [11:0] bird_loc_y,
  input  logic        report_req,
  output logic        tx_pin,
  output logic        busy,
  output logic        frame_done
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic             pending_q, pending_d;
  logic [1:0]       state_prev_q, state_prev_d;
  logic [1:0]       snap_state_q, snap_state_d;
  logic [11:0]      snap_y_q, snap_y_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             trig;
  logic             bit_end;
  logic [7:0]       b1, b2, b3;
  logic [7:0]       cur_byte;

  assign trig    = report_req | (state != state_prev_q);
  assign bit_end = (bit_cnt_q == CNT_LAST);

  // Payload always comes from the registered snapshot, never the live inputs.
  assign b1 = {6'b0, snap_state_q};
  assign b2 = {4'b0, snap_y_q[11:8]};
  assign b3 = snap_y_q[7:0];

  always_comb begin
    fsm_d        = fsm_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    pending_d    = pending_q | trig;
    state_prev_d = state;
    snap_state_d = snap_state_q;
    snap_y_d     = snap_y_q;

    case (fsm_q)
      IDLE, DONE: begin
        // DONE starts the next frame directly so a request landing on frame_done waits no extra cycle.
        if (trig || pending_q) begin
          snap_state_d = state;
          snap_y_d     = bird_loc_y;
          pending_d    = 1'b0;
          fsm_d        = START;
          bit_cnt_d    = '0;
          bit_idx_d    = '0;
          byte_idx_d   = '0;
        end else begin
          fsm_d = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          fsm_d     = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            fsm_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (byte_idx_q == 3'd4) begin
            fsm_d = DONE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            fsm_d      = START;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase

    case (byte_idx_d)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = b1;
      3'd2:    cur_byte = b2;
      3'd3:    cur_byte = b3;
      default: cur_byte = b1 ^ b2 ^ b3;
    endcase

    // Outputs are decoded from next-state values so they register glitch-free on the same edge.
    tx_d         = 1'b1;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    case (fsm_d)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = cur_byte[bit_idx_d];
        busy_d = 1'b1;
      end
      STOP:    busy_d = 1'b1;
      DONE:    frame_done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      pending_q    <= 1'b0;
      state_prev_q <= state;
      snap_state_q <= '0;
      snap_y_q     <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      pending_q    <= pending_d;
      state_prev_q <= state_prev_d;
      snap_state_q <= snap_state_d;
      snap_y_q     <= snap_y_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_pin     = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
